ofm_sram_reader: RTL and testbench

OFM_SRAM_READER -- requirements
Module: ofm_sram_reader

---
 rtl/ofm_sram_reader.sv | 185 ++++++++++++++++++
 tb/tb_ofm_sram_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ofm_sram_reader.sv
// Reads a run of OFM bytes from a 1-cycle-latency SRAM and packs PACK bytes
// per output word (little-endian) onto a valid/ready stream.
module ofm_sram_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 11,
    parameter int PACK       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_BITS-1:0]       base_addr,
    input  logic [11:0]                len,
    output logic                       busy,
    output logic                       done,
    output logic                       sram_write_en,
    output logic [ADDR_BITS-1:0]       sram_addr,
    output logic [DATA_WIDTH-1:0]      sram_wdata,
    input  logic [DATA_WIDTH-1:0]      sram_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH*PACK-1:0] out_data,
    output logic                       out_last
);
    localparam int CW = $clog2(PACK + 1);
    localparam int OW = DATA_WIDTH * PACK;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [11:0]          issue_left_q, issue_left_d;
    logic [11:0]          cap_left_q, cap_left_d;
    logic                 inflight_q, inflight_d;
    logic [OW-1:0]        asm_q, asm_d;
    logic [CW-1:0]        asm_cnt_q, asm_cnt_d;
    logic                 pend_q, pend_d;
    logic                 pend_last_q, pend_last_d;
    logic                 out_valid_q, out_valid_d;
    logic [OW-1:0]        out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;

    logic          out_free;
    logic          stall;
    logic          issue;
    logic          cap_final;
    logic          cap_complete;
    logic [CW:0]   fill;
    logic [OW-1:0] asm_merged;

    assign out_free     = !out_valid_q || out_ready;
    assign fill         = {1'b0, asm_cnt_q} + {{CW{1'b0}}, inflight_q};
    // Only stall when the bytes already committed would complete a word that has nowhere to go.
    assign stall        = out_valid_q && !out_ready && (fill == (CW+1)'(PACK));
    assign issue        = (state_q == S_READ) && (issue_left_q != 12'd0) && !stall;
    assign cap_final    = inflight_q && (cap_left_q == 12'd1);
    assign cap_complete = inflight_q && ((asm_cnt_q == CW'(PACK - 1)) || cap_final);

    always_comb begin
        asm_merged = asm_q;
        for (int k = 0; k < PACK; k++) begin
            if (asm_cnt_q == CW'(k)) begin
                asm_merged[k*DATA_WIDTH +: DATA_WIDTH] = sram_rdata;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        issue_left_d = issue_left_q;
        cap_left_d   = cap_left_q;
        inflight_d   = issue;
        asm_d        = asm_q;
        asm_cnt_d    = asm_cnt_q;
        pend_d       = pend_q;
        pend_last_d  = pend_last_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        // A word parked in the assembly register never coincides with a capture:
        // the stall guarantees nothing is in flight while it waits.
        if (pend_q && out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = asm_q;
            out_last_d  = pend_last_q;
            pend_d      = 1'b0;
            asm_d       = '0;
            asm_cnt_d   = '0;
        end else if (inflight_q) begin
            cap_left_d = cap_left_q - 12'd1;
            if (cap_complete && out_free) begin
                out_valid_d = 1'b1;
                out_data_d  = asm_merged;
                out_last_d  = cap_final;
                asm_d       = '0;
                asm_cnt_d   = '0;
            end else begin
                asm_d     = asm_merged;
                asm_cnt_d = asm_cnt_q + CW'(1);
                if (cap_complete) begin
                    pend_d      = 1'b1;
                    pend_last_d = cap_final;
                end
            end
        end

        if (issue) begin
            rd_ptr_d     = rd_ptr_q + ADDR_BITS'(1);
            issue_left_d = issue_left_q - 12'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rd_ptr_d     = base_addr;
                    issue_left_d = len;
                    cap_left_d   = len;
                    asm_d        = '0;
                    asm_cnt_d    = '0;
                    pend_d       = 1'b0;
                    state_d      = (len == 12'd0) ? S_FIN : S_READ;
                end
            end
            S_READ: begin
                if (issue && issue_left_q == 12'd1) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = S_FIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            issue_left_q <= '0;
            cap_left_q   <= '0;
            inflight_q   <= 1'b0;
            asm_q        <= '0;
            asm_cnt_q    <= '0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            issue_left_q <= issue_left_d;
            cap_left_q   <= cap_left_d;
            inflight_q   <= inflight_d;
            asm_q        <= asm_d;
            asm_cnt_q    <= asm_cnt_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

    assign busy          = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done          = (state_q == S_FIN);
    assign sram_write_en = 1'b0;
    assign sram_wdata    = '0;
    assign sram_addr     = rd_ptr_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_last      = out_last_q;
endmodule

// File: tb/tb_ofm_sram_reader.sv
// Directed bench for ofm_sram_reader with a behavioural 1-cycle-latency SRAM.
module tb_ofm_sram_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] base_addr = '0;
    logic [11:0] len = '0;
    logic        busy, done, sram_write_en;
    logic [10:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;

    logic [7:0]  mem [0:2047];
    logic [32:0] xfer_q [$];
    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    int          valid_cnt = 0;
    logic        stall_prev = 1'b0;
    logic [32:0] held_prev = '0;

    ofm_sram_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .sram_write_en(sram_write_en),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sram_rdata <= mem[sram_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transfers are logged at the falling edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        if (stall_prev) chk("stable_while_stalled", {out_valid, out_last, out_data}, {1'b1, held_prev});
        stall_prev = out_valid && !out_ready && !rst;
        held_prev  = {out_last, out_data};
        if (out_valid && out_ready) begin
            xfer_q.push_back({out_last, out_data});
            $display("xfer data=%08h last=%0d", out_data, out_last);
        end
        if (done) done_cnt++;
        if (out_valid) valid_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [10:0] b, input logic [11:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, done}, 64'd1);
        tick();
    endtask

    task automatic chk_words(input string tag, input int n, input logic [31:0] w0, input logic [31:0] w1);
        chk({tag, "_count"}, 64'(xfer_q.size()), 64'(n));
        if (xfer_q.size() >= 1) chk({tag, "_w0"}, 64'(xfer_q[0]), {31'd0, (n == 1), w0});
        if (xfer_q.size() >= 2) chk({tag, "_w1"}, 64'(xfer_q[1]), {31'd0, 1'b1, w1});
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = i[7:0];

        // Reset state
        tick();
        tick();
        chk("rst_outputs", {busy, done, out_valid, out_last, out_data, sram_addr},
            {1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 11'd0});
        chk("sram_we_wdata", {sram_write_en, sram_wdata}, 9'd0);
        rst = 1'b0;
        tick();

        // Basic readback with first-word latency
        xfer_q.delete();
        do_start(11'h010, 12'd8);
        chk("basic_busy", {63'd0, busy}, 64'd1);
        repeat (4) tick();
        chk("basic_valid_early", {63'd0, out_valid}, 64'd0);
        tick();
        chk("basic_word0", {out_valid, out_last, out_data}, {1'b1, 1'b0, 32'h13121110});
        repeat (4) tick();
        chk("basic_word1", {out_valid, out_last, out_data}, {1'b1, 1'b1, 32'h17161514});
        tick();
        chk("basic_done", {done, busy, out_valid}, 3'b100);
        tick();
        chk("basic_done_once", {63'd0, done}, 64'd0);
        chk_words("basic", 2, 32'h13121110, 32'h17161514);

        // Partial final word with address wrap
        xfer_q.delete();
        do_start(11'h7FE, 12'd6);
        chk("wrap_addr0", 64'(sram_addr), 64'h7FE);
        tick();
        chk("wrap_addr1", 64'(sram_addr), 64'h7FF);
        tick();
        chk("wrap_addr2", 64'(sram_addr), 64'h000);
        tick();
        chk("wrap_addr3", 64'(sram_addr), 64'h001);
        tick();
        chk("wrap_addr4", 64'(sram_addr), 64'h002);
        tick();
        chk("wrap_addr5", 64'(sram_addr), 64'h003);
        wait_done("wrap_done", 50);
        chk_words("wrap", 2, 32'h0100FFFE, 32'h00000302);

        // Backpressure with long low stretches
        xfer_q.delete();
        do_start(11'h100, 12'd16);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (cyc < 10 || (cyc >= 30 && cyc < 40)) out_ready = 1'b0;
            else out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        chk("bp_done", {63'd0, done}, 64'd1);
        tick();
        chk("bp_count", 64'(xfer_q.size()), 64'd4);
        if (xfer_q.size() == 4) begin
            chk("bp_w0", 64'(xfer_q[0]), {31'd0, 1'b0, 32'h03020100});
            chk("bp_w1", 64'(xfer_q[1]), {31'd0, 1'b0, 32'h07060504});
            chk("bp_w2", 64'(xfer_q[2]), {31'd0, 1'b0, 32'h0B0A0908});
            chk("bp_w3", 64'(xfer_q[3]), {31'd0, 1'b1, 32'h0F0E0D0C});
        end

        // len=0, then a start during READ that must be ignored
        valid_cnt = 0;
        do_start(11'h040, 12'd0);
        chk("len0_done", {done, busy, out_valid}, 3'b100);
        tick();
        chk("len0_idle", {done, busy, 28'd0, valid_cnt[3:0]}, 32'd0);
        xfer_q.delete();
        do_start(11'h010, 12'd8);
        tick();
        do_start(11'h200, 12'd4);
        wait_done("ign_done", 50);
        chk_words("ign", 2, 32'h13121110, 32'h17161514);
        chk("ign_not_busy", {63'd0, busy}, 64'd0);

        // Reset mid-readback
        xfer_q.delete();
        do_start(11'h020, 12'd32);
        for (int n = 0; n < 100 && xfer_q.size() < 2; n++) tick();
        chk("mid_two_words", 64'(xfer_q.size()), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {busy, done, out_valid, out_last, out_data, sram_addr},
            {1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 11'd0});
        tick();
        tick();
        rst = 1'b0;
        done_cnt  = 0;
        valid_cnt = 0;
        repeat (12) tick();
        chk("mid_no_done", 64'(done_cnt), 64'd0);
        chk("mid_no_valid", 64'(valid_cnt), 64'd0);
        xfer_q.delete();
        do_start(11'h010, 12'd8);
        wait_done("mid_restart_done", 50);
        chk_words("mid_restart", 2, 32'h13121110, 32'h17161514);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
